// File: rtl/note_recorder_if.sv
// Event capture and replay handshake bundle for note_recorder.
// The slave side is the recorder; the master side is the surrounding system
// (key-hit decoder, control pulses and the sound generator).
interface note_recorder_if #(
    parameter int OCT_W  = 3,
    parameter int NOTE_W = 3,
    parameter int LEN_W  = 3,
    parameter int DEPTH  = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    // mode control
    logic              en;
    logic              rec_start;
    logic              stop;
    logic              play_start;

    // incoming events from the key-hit decoder
    logic              capture;
    logic [OCT_W-1:0]  octave_in;
    logic [NOTE_W-1:0] note_in;
    logic [LEN_W-1:0]  length_in;

    // sound generator handshake
    logic              sound_over;
    logic              play_go;
    logic [OCT_W-1:0]  octave_out;
    logic [NOTE_W-1:0] note_out;
    logic [LEN_W-1:0]  length_out;

    // status
    logic [ADDR_W:0]   count;
    logic              full;
    logic              recording;
    logic              playing;

    modport master (
        output en, rec_start, stop, play_start,
        output capture, octave_in, note_in, length_in,
        output sound_over,
        input  play_go, octave_out, note_out, length_out,
        input  count, full, recording, playing
    );

    modport slave (
        input  en, rec_start, stop, play_start,
        input  capture, octave_in, note_in, length_in,
        input  sound_over,
        output play_go, octave_out, note_out, length_out,
        output count, full, recording, playing
    );
endinterface

// File: rtl/note_recorder.sv
// Records (octave, note, length) events into a small buffer and replays them
// in order, issuing each note only after the sound generator reports the
// previous one finished.
module note_recorder #(
    parameter int OCT_W  = 3,
    parameter int NOTE_W = 3,
    parameter int LEN_W  = 3,
    parameter int DEPTH  = 32
) (
    input  logic clk,
    input  logic rst,
    note_recorder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int EV_W   = OCT_W + NOTE_W + LEN_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [OCT_W-1:0]  oct_q, oct_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [EV_W-1:0]   mem_q [DEPTH];
    logic              wr_en;
    logic              play_go_c;
    logic              full;
    logic [ADDR_W:0]   nxt_ptr;
    logic [EV_W-1:0]   rd_data;

    assign full = (count_q == DEPTH_C);

    // Pointer of the entry the next ISSUE will play: entry 0 when starting
    // from IDLE, otherwise the one after the note just finished. Reading it
    // one cycle early lets the output registers be loaded on entry to ISSUE.
    assign nxt_ptr = (state_q == S_WAIT_DONE) ? rd_ptr_q + 1'b1 : '0;
    assign rd_data = mem_q[nxt_ptr[ADDR_W-1:0]];

    // Next-state, counter, pointer and output-data computation
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        oct_d     = oct_q;
        note_d    = note_q;
        len_d     = len_q;
        wr_en     = 1'b0;
        play_go_c = 1'b0;

        if (!bus.en) begin
            state_d = S_IDLE;
        end else if (bus.stop) begin
            state_d = S_IDLE;
        end else if (bus.rec_start && (state_q == S_IDLE || state_q == S_REC)) begin
            count_d = '0;
            state_d = S_REC;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.play_start && count_q != '0) begin
                        rd_ptr_d = '0;
                        state_d  = S_ISSUE;
                    end
                end
                S_REC: begin
                    // a capture on a full buffer is dropped, count saturates
                    if (bus.capture && !full) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
                S_ISSUE: begin
                    play_go_c = 1'b1;
                    state_d   = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // ignore an over flag still high from before the issue
                    if (!bus.sound_over) state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.sound_over) begin
                        rd_ptr_d = nxt_ptr;
                        state_d  = (nxt_ptr == count_q) ? S_IDLE : S_ISSUE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // output data is loaded only on entry to ISSUE and held otherwise
        if (state_d == S_ISSUE) begin
            {oct_d, note_d, len_d} = rd_data;
        end
    end

    // Control and output-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            oct_q    <= '0;
            note_q   <= '0;
            len_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            oct_q    <= oct_d;
            note_q   <= note_d;
            len_q    <= len_d;
        end
    end

    // Event buffer write port
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; its contents are meaningless until written and count guards every read.
        if (wr_en) begin
            mem_q[count_q[ADDR_W-1:0]] <= {bus.octave_in, bus.note_in, bus.length_in};
        end
    end

    assign bus.play_go    = play_go_c;
    assign bus.octave_out = oct_q;
    assign bus.note_out   = note_q;
    assign bus.length_out = len_q;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.recording  = (state_q == S_REC);
    assign bus.playing    = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) ||
                            (state_q == S_WAIT_DONE);
endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: records, replays against a simple sound
// generator model, and exercises stop, overflow, enable and reset cases.
module tb_note_recorder;
    localparam int DEPTH = 32;

    logic clk;
    logic rst;

    note_recorder_if #(.OCT_W(3), .NOTE_W(3), .LEN_W(3), .DEPTH(DEPTH)) bus ();

    note_recorder #(.OCT_W(3), .NOTE_W(3), .LEN_W(3), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sound generator model: over goes low on the edge after play_go and
    // rises again after five low cycles.
    logic     over_m;
    int       busy_cnt;
    assign bus.sound_over = over_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            over_m   <= 1'b1;
            busy_cnt <= 0;
        end else if (bus.play_go) begin
            over_m   <= 1'b0;
            busy_cnt <= 5;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) over_m <= 1'b1;
        end
    end

    // Monitor: log every issued note and flag any issue that was not
    // preceded by the sound generator going busy since the last issue.
    logic [8:0] got_q [$];
    bit         go_seen;
    bit         low_seen;
    int         gap_err;

    always @(negedge clk) begin
        if (rst) begin
            go_seen  = 1'b0;
            low_seen = 1'b0;
            gap_err  = 0;
        end else if (bus.play_go) begin
            if (go_seen && !low_seen) gap_err++;
            got_q.push_back({bus.octave_out, bus.note_out, bus.length_out});
            go_seen  = 1'b1;
            low_seen = 1'b0;
        end else if (!bus.sound_over) begin
            low_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rec_start();
        bus.rec_start = 1'b1; tick(); bus.rec_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    task automatic pulse_play_start();
        bus.play_start = 1'b1; tick(); bus.play_start = 1'b0;
    endtask

    task automatic do_capture(input logic [8:0] ev);
        {bus.octave_in, bus.note_in, bus.length_in} = ev;
        bus.capture = 1'b1; tick(); bus.capture = 1'b0;
    endtask

    // wait for playback to end; an expired budget is a failed comparison
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.playing && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(bus.playing), 32'd0);
    endtask

    function automatic logic [8:0] ovf_ev(input int i);
        return 9'((i * 37 + 5) % 512);
    endfunction

    initial begin
        int n;
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.rec_start  = 1'b0;
        bus.stop       = 1'b0;
        bus.play_start = 1'b0;
        bus.capture    = 1'b0;
        bus.octave_in  = '0;
        bus.note_in    = '0;
        bus.length_in  = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_count",     32'(bus.count),      32'd0);
        check("rst_full",      32'(bus.full),       32'd0);
        check("rst_recording", 32'(bus.recording),  32'd0);
        check("rst_playing",   32'(bus.playing),    32'd0);
        check("rst_play_go",   32'(bus.play_go),    32'd0);
        check("rst_data",      32'({bus.octave_out, bus.note_out, bus.length_out}), 32'd0);

        // play_start on an empty buffer is ignored
        pulse_play_start();
        check("empty_play_go", 32'(bus.play_go), 32'd0);
        check("empty_playing", 32'(bus.playing), 32'd0);
        repeat (5) tick();
        check("empty_no_notes", 32'(got_q.size()), 32'd0);

        // record three events
        pulse_rec_start();
        check("rec_recording", 32'(bus.recording), 32'd1);
        check("rec_count0",    32'(bus.count),     32'd0);
        do_capture({3'd4, 3'd1, 3'd2});
        check("rec_count1",    32'(bus.count),     32'd1);
        do_capture({3'd4, 3'd3, 3'd1});
        do_capture({3'd5, 3'd7, 3'd4});
        pulse_stop();
        check("rec3_count",     32'(bus.count),     32'd3);
        check("rec3_recording", 32'(bus.recording), 32'd0);
        check("rec3_full",      32'(bus.full),      32'd0);

        // capture in IDLE is ignored
        do_capture({3'd1, 3'd1, 3'd1});
        check("idle_capture_count", 32'(bus.count), 32'd3);

        // replay three notes
        got_q.delete();
        pulse_play_start();
        check("play_go_first",   32'(bus.play_go), 32'd1);
        check("play_data_first", 32'({bus.octave_out, bus.note_out, bus.length_out}),
              32'({3'd4, 3'd1, 3'd2}));
        check("play_playing",    32'(bus.playing), 32'd1);
        tick();
        check("play_go_one_cycle", 32'(bus.play_go), 32'd0);
        wait_idle("play3", 200);
        check("play3_n",  32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("play3_ev0", 32'(got_q[0]), 32'({3'd4, 3'd1, 3'd2}));
            check("play3_ev1", 32'(got_q[1]), 32'({3'd4, 3'd3, 3'd1}));
            check("play3_ev2", 32'(got_q[2]), 32'({3'd5, 3'd7, 3'd4}));
        end
        check("play3_hold", 32'({bus.octave_out, bus.note_out, bus.length_out}),
              32'({3'd5, 3'd7, 3'd4}));
        check("play3_gap", 32'(gap_err), 32'd0);

        // stop during the second note
        repeat (10) tick();
        got_q.delete();
        pulse_play_start();
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("stop2_reached", 32'(got_q.size()), 32'd2);
        pulse_stop();
        check("stop2_playing", 32'(bus.playing), 32'd0);
        repeat (30) tick();
        check("stop2_no_third", 32'(got_q.size()), 32'd2);
        check("stop2_count",    32'(bus.count),    32'd3);

        // capture together with stop in REC is not stored
        pulse_rec_start();
        do_capture({3'd1, 3'd2, 3'd3});
        bus.stop = 1'b1;
        do_capture({3'd6, 3'd6, 3'd6});
        bus.stop = 1'b0;
        check("cap_stop_count",     32'(bus.count),     32'd1);
        check("cap_stop_recording", 32'(bus.recording), 32'd0);

        // en low during REC with a pending capture
        pulse_rec_start();
        do_capture({3'd2, 3'd5, 3'd6});
        bus.en = 1'b0;
        do_capture({3'd7, 3'd0, 3'd7});
        check("en_low_count",     32'(bus.count),     32'd1);
        check("en_low_recording", 32'(bus.recording), 32'd0);
        bus.en = 1'b1;
        tick();
        got_q.delete();
        pulse_play_start();
        wait_idle("en_play", 100);
        check("en_play_n", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check("en_play_ev0", 32'(got_q[0]), 32'({3'd2, 3'd5, 3'd6}));

        // overflow: DEPTH+2 captures
        pulse_rec_start();
        for (int i = 0; i < DEPTH + 2; i++) begin
            do_capture(ovf_ev(i));
            if (i == DEPTH - 2) check("ovf_not_full", 32'(bus.full), 32'd0);
        end
        check("ovf_count",     32'(bus.count),     32'(DEPTH));
        check("ovf_full",      32'(bus.full),      32'd1);
        check("ovf_recording", 32'(bus.recording), 32'd1);
        pulse_stop();
        got_q.delete();
        pulse_play_start();
        wait_idle("ovf_play", 800);
        check("ovf_play_n", 32'(got_q.size()), 32'(DEPTH));
        if (got_q.size() == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                check($sformatf("ovf_ev%0d", i), 32'(got_q[i]), 32'(ovf_ev(i)));
            end
        end
        check("ovf_gap", 32'(gap_err), 32'd0);

        // reset during WAIT_DONE
        repeat (5) tick();
        got_q.delete();
        pulse_play_start();
        repeat (3) tick();
        check("mid_rst_pre_playing", 32'(bus.playing), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count",     32'(bus.count),   32'd0);
        check("mid_rst_playing",   32'(bus.playing), 32'd0);
        check("mid_rst_play_go",   32'(bus.play_go), 32'd0);
        check("mid_rst_recording", 32'(bus.recording), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
